// File: rtl/xy_store_unit_if.sv
// Memory write port bundle for the X/Y store unit.
// Master drives the request, slave answers with ready.
interface xy_store_unit_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              mem_wr_valid;
  logic              mem_wr_ready;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;

  modport master (
    output mem_wr_valid,
    output mem_wr_addr,
    output mem_wr_data,
    input  mem_wr_ready
  );

  modport slave (
    input  mem_wr_valid,
    input  mem_wr_addr,
    input  mem_wr_data,
    output mem_wr_ready
  );
endinterface

// File: rtl/xy_store_unit.sv
// X/Y register store path: capture on command, one memory write.
// Optional REQ timeout abort enabled by XY_STORE_TIMEOUT_EN.
module xy_store_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
`ifdef XY_STORE_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 15
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_x,
  input  logic              st_y,
  input  logic [DATA_W-1:0] x_val,
  input  logic [DATA_W-1:0] y_val,
  input  logic [ADDR_W-1:0] st_addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  xy_store_unit_if.master   mem
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_cap_x;
  logic              w_cap_y;
  logic              w_hs;
  logic              w_abort;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  assign w_hs = (r_state == S_REQ)
              & mem.mem_wr_ready;

`ifdef XY_STORE_TIMEOUT_EN
  localparam int CNT_W =
    $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             w_expired;

  assign w_expired = (r_state == S_REQ)
                   & (r_cnt == CNT_LAST);

  // Count REQ cycles without handshake; idle clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_cnt <= '0;
    else if (r_state != S_REQ)
      r_cnt <= '0;
    else if (!w_hs)
      r_cnt <= r_cnt + 1'b1;
  end

  // Error flag rides alongside the DONE pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_err <= 1'b0;
    else
      r_err <= w_abort;
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // Next state and capture strobes; X wins over Y.
  always_comb begin
    w_next  = r_state;
    w_cap_x = 1'b0;
    w_cap_y = 1'b0;
    w_abort = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (st_x) begin
          w_cap_x = 1'b1;
          w_next  = S_REQ;
        end else if (st_y) begin
          w_cap_y = 1'b1;
          w_next  = S_REQ;
        end
      end
      S_REQ: begin
        if (w_hs) begin
          w_next = S_DONE;
        end
`ifdef XY_STORE_TIMEOUT_EN
        else if (w_expired) begin
          w_abort = 1'b1;
          w_next  = S_DONE;
        end
`endif
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Capture address and selected register value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr <= '0;
      r_data <= '0;
    end else if (w_cap_x) begin
      r_addr <= st_addr;
      r_data <= x_val;
    end else if (w_cap_y) begin
      r_addr <= st_addr;
      r_data <= y_val;
    end
  end

  assign busy             = (r_state != S_IDLE);
  assign done             = (r_state == S_DONE);
  assign mem.mem_wr_valid = (r_state == S_REQ);
  assign mem.mem_wr_addr  = r_addr;
  assign mem.mem_wr_data  = r_data;

endmodule
